// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt block: register addresses and
// the debounce threshold value loaded at reset.
package gpio_irq_pkg;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_POL    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;  // read LEVEL, write THR

  localparam int THR_RST = 4;

endpackage

// File: rtl/gpio_debounce.sv
// One pin: 2-flop synchronizer, stability counter and debounced level, plus
// strobes flagging the edge on which the debounced level rises or falls.
module gpio_debounce #(
  parameter int DB_BITS = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pin,
  input  logic [DB_BITS-1:0] thr_m1,
  output logic               level,
  output logic               rise,
  output logic               fall
);

  logic               s1;
  logic               s2;
  logic [DB_BITS-1:0] cnt;
  logic               flip;

  // NOTE: sequential state uses non-blocking assignments so s2 takes the
  // pre-edge value of s1 and the counter sees the pre-edge level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == thr_m1) begin
        level <= s2;
        cnt   <= '0;
      end else if (cnt > thr_m1) begin
        // threshold was lowered below a count in progress: restart
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign flip = (s2 != level) && (cnt == thr_m1);
  assign rise = flip && s2;
  assign fall = flip && !s2;

endmodule

// File: rtl/gpio_irq.sv
// GPIO edge-interrupt block: per-pin debouncers feeding a sticky STATUS
// register selected by POL, gated by MASK into a level interrupt.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DB_BITS = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sel,
  input  logic             wen,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  input  logic [WIDTH-1:0] pins,
  output logic             irq
);

  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   pol;
  logic [WIDTH-1:0]   status;
  logic [DB_BITS-1:0] thr;
  logic [DB_BITS-1:0] thr_m1;
  logic [WIDTH-1:0]   level;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   fall;
  logic [WIDTH-1:0]   set;
  logic [WIDTH-1:0]   clr;
  logic               wr;

  // a threshold of zero behaves as one
  assign thr_m1 = (thr == '0) ? '0 : thr - 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(.DB_BITS(DB_BITS)) u_db (
      .clk    (clk),
      .rstn   (rstn),
      .pin    (pins[i]),
      .thr_m1 (thr_m1),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign wr  = sel && wen;
  assign set = (pol & rise) | (~pol & fall);
  assign clr = (wr && addr == ADDR_STATUS) ? datain : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask   <= '0;
      pol    <= '0;
      status <= '0;
      thr    <= DB_BITS'(THR_RST);
    end else begin
      // set is OR-ed in after the clear so a coincident event wins
      status <= (status & ~clr) | set;
      if (wr && addr == ADDR_MASK)  mask <= datain;
      if (wr && addr == ADDR_POL)   pol  <= datain;
      if (wr && addr == ADDR_LEVEL) thr  <= datain[DB_BITS-1:0];
    end
  end

  // NOTE: dataout gets a default before the case so no latch is inferred.
  always_comb begin
    dataout = '0;
    if (sel && !wen) begin
      case (addr)
        ADDR_MASK:   dataout = mask;
        ADDR_POL:    dataout = pol;
        ADDR_STATUS: dataout = status;
        ADDR_LEVEL:  dataout = level;
        default:     dataout = '0;
      endcase
    end
  end

  assign irq = |(status & mask);

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq: directed scenarios plus randomized pin/bus traffic,
// scored against a cycle-level behavioural model through an expectation queue.
module tb_gpio_irq;
  import gpio_irq_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         sel = 1'b0;
  logic         wen = 1'b0;
  logic [1:0]   addr = '0;
  logic [W-1:0] datain = '0;
  logic [W-1:0] dataout;
  logic [W-1:0] pins = '0;
  logic         irq;

  gpio_irq #(.WIDTH(W), .DB_BITS(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sel     (sel),
    .wen     (wen),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .pins    (pins),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         irq;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_db, m_mask, m_pol, m_status;
  int           m_cnt[W];
  int           m_thr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    m_mask = '0; m_pol = '0; m_status = '0;
    m_thr = 4;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [W-1:0] model_read(input logic s, input logic w, input logic [1:0] a);
    if (!s || w) return '0;
    case (a)
      ADDR_MASK:   return m_mask;
      ADDR_POL:    return m_pol;
      ADDR_STATUS: return m_status;
      default:     return m_db;
    endcase
  endfunction

  // One rising edge: a pin's debounced level follows its synchronized value
  // once that value has disagreed for max(THR,1) consecutive edges.
  task automatic model_edge(input logic s, input logic w, input logic [1:0] a,
                            input logic [W-1:0] d, input logic [W-1:0] p);
    int           need;
    logic [W-1:0] rose, fell, clr;
    need = (m_thr == 0) ? 1 : m_thr;
    rose = '0;
    fell = '0;
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] == m_db[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] + 1 == need) begin
        if (m_s2[i]) rose[i] = 1'b1;
        else         fell[i] = 1'b1;
        m_cnt[i] = 0;
      end else if (m_cnt[i] + 1 > need) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    clr = (s && w && a == ADDR_STATUS) ? d : '0;
    m_status = (m_status & ~clr) | (rose & m_pol) | (fell & ~m_pol);
    m_db = m_db ^ rose ^ fell;
    if (s && w && a == ADDR_MASK)  m_mask = d;
    if (s && w && a == ADDR_POL)   m_pol = d;
    if (s && w && a == ADDR_LEVEL) m_thr = int'(d[7:0]);
    m_s2 = m_s1;
    m_s1 = p;
  endtask

  // Drive one cycle; the expectation for this cycle's outputs is queued first.
  task automatic step(input logic s, input logic w, input logic [1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] p);
    exp_t e;
    sel = s; wen = w; addr = a; datain = d; pins = p;
    e.data = model_read(s, w, a);
    e.irq  = |(m_status & m_mask);
    sb.push_back(e);
    @(posedge clk);
    #1;
    model_edge(s, w, a, d, p);
  endtask

  task automatic idle(input int n, input logic [W-1:0] p);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, '0, p);
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d, input logic [W-1:0] p);
    step(1'b1, 1'b1, a, d, p);
  endtask

  task automatic peek(input logic [1:0] a, input logic [W-1:0] exp_d, input logic exp_irq,
                      input string name);
    sel = 1'b1; wen = 1'b0; addr = a;
    #1;
    check(name, dataout, exp_d);
    check({name, "_irq"}, irq, exp_irq);
  endtask

  task automatic do_reset(input logic [W-1:0] p);
    rstn = 1'b0;
    sel = 1'b0; wen = 1'b0; pins = p;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // monitor: one expectation per driven cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_dataout", dataout, e.data);
        check("sb_irq", irq, e.irq);
      end
    end
  end

  initial begin
    logic [W-1:0] p;
    int           r;

    do_reset('0);
    peek(ADDR_MASK,   16'h0000, 1'b0, "rst_mask");
    peek(ADDR_POL,    16'h0000, 1'b0, "rst_pol");
    peek(ADDR_STATUS, 16'h0000, 1'b0, "rst_status");
    peek(ADDR_LEVEL,  16'h0000, 1'b0, "rst_level");

    // default THR=4: status appears at edge k+5, not k+4
    wr(ADDR_POL, 16'hFFFF, 16'h0000);
    wr(ADDR_MASK, 16'h0001, 16'h0000);
    idle(5, 16'h0001);
    peek(ADDR_STATUS, 16'h0000, 1'b0, "lat_k4");
    idle(1, 16'h0001);
    peek(ADDR_STATUS, 16'h0001, 1'b1, "lat_k5");
    wr(ADDR_STATUS, 16'h0001, 16'h0001);
    peek(ADDR_STATUS, 16'h0000, 1'b0, "w1c_bit0");

    // THR=3, two-cycle glitch on pin1 is rejected
    wr(ADDR_LEVEL, 16'h0003, 16'h0001);
    idle(2, 16'h0003);
    idle(8, 16'h0001);
    peek(ADDR_LEVEL, 16'h0001, 1'b0, "glitch_level");
    peek(ADDR_STATUS, 16'h0000, 1'b0, "glitch_status");

    // falling polarity on pin2
    wr(ADDR_POL, 16'hFFFB, 16'h0001);
    idle(10, 16'h0005);
    peek(ADDR_STATUS, 16'h0000, 1'b0, "pol_fall_after_rise");
    peek(ADDR_LEVEL, 16'h0005, 1'b0, "pol_level_high");
    idle(10, 16'h0001);
    peek(ADDR_STATUS, 16'h0004, 1'b0, "pol_fall_after_fall");

    // build STATUS=0x0005, then partial W1C
    idle(10, 16'h0000);
    idle(10, 16'h0001);
    peek(ADDR_STATUS, 16'h0005, 1'b1, "status_5");
    wr(ADDR_STATUS, 16'h0001, 16'h0001);
    peek(ADDR_STATUS, 16'h0004, 1'b0, "w1c_partial");
    wr(ADDR_STATUS, 16'h0004, 16'h0001);
    peek(ADDR_STATUS, 16'h0000, 1'b0, "w1c_bit2");
    // W1C of bit 2 on the same edge as a new bit-2 fall event: set wins
    idle(10, 16'h0005);
    idle(4, 16'h0001);
    wr(ADDR_STATUS, 16'h0004, 16'h0001);
    peek(ADDR_STATUS, 16'h0004, 1'b0, "set_beats_clear");

    // masking hides irq but not status
    wr(ADDR_MASK, 16'h0000, 16'h0001);
    idle(10, 16'h0009);
    peek(ADDR_STATUS, 16'h000C, 1'b0, "masked_status");
    wr(ADDR_MASK, 16'h0008, 16'h0009);
    peek(ADDR_MASK, 16'h0008, 1'b1, "unmask_irq");

    // POL changes alone leave STATUS untouched
    wr(ADDR_POL, 16'h0000, 16'h0009);
    wr(ADDR_POL, 16'hFFFF, 16'h0009);
    peek(ADDR_STATUS, 16'h000C, 1'b1, "pol_change_no_effect");

    // THR=0 behaves as a one-cycle debounce
    wr(ADDR_STATUS, 16'hFFFF, 16'h0009);
    wr(ADDR_LEVEL, 16'h0000, 16'h0009);
    idle(2, 16'h0019);
    peek(ADDR_STATUS, 16'h0000, 1'b0, "thr0_early");
    idle(1, 16'h0019);
    peek(ADDR_STATUS, 16'h0010, 1'b0, "thr0_set");

    // reset mid-count, pin0 held high through reset
    wr(ADDR_LEVEL, 16'h0008, 16'h0019);
    idle(4, 16'h0059);
    do_reset(16'h0001);
    peek(ADDR_STATUS, 16'h0000, 1'b0, "reset_abort_status");
    wr(ADDR_LEVEL, 16'h0000, 16'h0001);
    wr(ADDR_POL, 16'hFFFF, 16'h0001);
    peek(ADDR_STATUS, 16'h0000, 1'b0, "held_pin_edge2");
    idle(1, 16'h0001);
    peek(ADDR_STATUS, 16'h0001, 1'b0, "held_pin_edge3");
    peek(ADDR_LEVEL, 16'h0001, 1'b0, "held_pin_level");

    // randomized traffic against the model
    p = 16'h0001;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) p = p ^ (16'h1 << $urandom_range(0, W - 1));
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: step(1'b1, 1'b0, 2'($urandom_range(0, 3)), W'($urandom), p);
        5: wr(ADDR_MASK, W'($urandom), p);
        6: wr(ADDR_POL, W'($urandom), p);
        7: wr(ADDR_STATUS, W'($urandom), p);
        8: wr(ADDR_LEVEL, W'($urandom_range(0, 6)), p);
        default: idle(1, p);
      endcase
    end

    idle(1, p);
    sel = 1'b0;
    #20;
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
